// File: rtl/gouram_trace_pkg.sv
// gouram_trace_pkg: shared drain FSM state type and default request timeout.
// Ports: none (package).
package gouram_trace_pkg;
   typedef enum logic [1:0] {IDLE, REQUEST, WAIT_VALID, OUTPUT} drain_state_t;
   localparam int DEFAULT_TIMEOUT = 15;
endpackage

// File: rtl/trace_drain_arbiter_picker.sv
// rr_priority_picker: combinational round-robin pick of the first requester after last_grant.
// Ports: req (request vector), last_grant (previous winner),
//        grant (chosen index, 0 when none), any_req (some request is set).
module rr_priority_picker #(
   parameter int NUM_SOURCES = 2,
   localparam int SRC_W = $clog2(NUM_SOURCES)
) (
   input  logic [NUM_SOURCES-1:0] req,
   input  logic [SRC_W-1:0]       last_grant,
   output logic [SRC_W-1:0]       grant,
   output logic                   any_req
);
   logic [SRC_W-1:0] idx;
   // Walk the offsets from farthest to nearest so the nearest requester after last_grant wins.
   always_comb begin
      grant = '0;
      idx = '0;
      for (int i = NUM_SOURCES; i >= 1; i--) begin
         idx = SRC_W'((int'(last_grant) + i) % NUM_SOURCES);
         if (req[idx]) grant = idx;
      end
   end
   assign any_req = |req;
endmodule

// File: rtl/trace_drain_arbiter.sv
// trace_drain_arbiter: round-robin drain of NUM_SOURCES trace buffers onto one valid/ready output.
// Ports: clk, rst_n (async active-low), enable (gates new grants only),
//        src_data_present/src_data_valid/src_trace_element/src_dec_stage_end (buffer side),
//        src_data_request (one-hot request pulse), out_valid/out_ready/out_trace_element/
//        out_dec_stage_end/out_source_id (consumer side), timeout_error (abandoned request pulse).
module trace_drain_arbiter
   import gouram_trace_pkg::*;
#(
   parameter int NUM_SOURCES = 2,
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter type trace_output = int,
   localparam int SRC_W = $clog2(NUM_SOURCES)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [NUM_SOURCES-1:0] src_data_present,
   input  logic [NUM_SOURCES-1:0] src_data_valid,
   input  trace_output            src_trace_element [NUM_SOURCES],
   input  integer                 src_dec_stage_end [NUM_SOURCES],
   output logic [NUM_SOURCES-1:0] src_data_request,
   output logic                   out_valid,
   input  logic                   out_ready,
   output trace_output            out_trace_element,
   output integer                 out_dec_stage_end,
   output logic [SRC_W-1:0]       out_source_id,
   output logic                   timeout_error
);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   drain_state_t     state;
   logic [SRC_W-1:0] grant, last_grant, pick;
   logic [TMR_W-1:0] timer;
   logic             any_req;
   rr_priority_picker #(.NUM_SOURCES(NUM_SOURCES)) u_picker (
      .req(src_data_present),
      .last_grant(last_grant),
      .grant(pick),
      .any_req(any_req)
   );
   // Decoded from registered state only, so the request never depends combinationally on inputs.
   assign src_data_request = (state == REQUEST) ? NUM_SOURCES'(1) << grant : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
         last_grant <= SRC_W'(NUM_SOURCES - 1);
         timer <= '0;
         out_valid <= 1'b0;
         out_trace_element <= '0;
         out_dec_stage_end <= 0;
         out_source_id <= '0;
         timeout_error <= 1'b0;
      end else begin
         timeout_error <= 1'b0;
         case (state)
            IDLE: if (enable && any_req) begin
               grant <= pick;
               state <= REQUEST;
            end
            REQUEST: begin
               timer <= '0;
               state <= WAIT_VALID;
            end
            WAIT_VALID: if (src_data_valid[grant]) begin
               out_trace_element <= src_trace_element[grant];
               out_dec_stage_end <= src_dec_stage_end[grant];
               out_source_id <= grant;
               out_valid <= 1'b1;
               state <= OUTPUT;
            end else if (timer == TMR_W'(TIMEOUT - 1)) begin
               // The TIMEOUT-th empty wait cycle: give up and let the next source have a turn.
               timeout_error <= 1'b1;
               last_grant <= grant;
               state <= IDLE;
            end else begin
               timer <= timer + 1'b1;
            end
            OUTPUT: if (out_ready) begin
               out_valid <= 1'b0;
               last_grant <= grant;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_trace_drain_arbiter.sv
// tb_trace_drain_arbiter: randomized bench with a transaction-timeline reference model.
module tb_trace_drain_arbiter;
   localparam int N = 2;
   localparam int TO = 15;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         enable = 1'b0;
   logic         out_ready = 1'b0;
   logic [N-1:0] src_data_present = '0;
   logic [N-1:0] src_data_valid = '0;
   logic [N-1:0] src_data_request;
   int           src_trace_element [N];
   integer       src_dec_stage_end [N];
   logic         out_valid, timeout_error;
   int           out_trace_element;
   integer       out_dec_stage_end;
   logic [0:0]   out_source_id;
   trace_drain_arbiter #(.NUM_SOURCES(N), .TIMEOUT(TO)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .src_data_present(src_data_present),
      .src_data_valid(src_data_valid),
      .src_trace_element(src_trace_element),
      .src_dec_stage_end(src_dec_stage_end),
      .src_data_request(src_data_request),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_trace_element(out_trace_element),
      .out_dec_stage_end(out_dec_stage_end),
      .out_source_id(out_source_id),
      .timeout_error(timeout_error)
   );
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Stimulus knobs.
   bit       rand_pres = 0;
   logic [N-1:0] force_pres = '0;
   int       en_pct = 100, rdy_pct = 100, stale_pct = 0, noise_pct = 0, d_fix = 2;
   bit       fix_data = 0;

   // Reference timeline: cycle numbers of the next arbitration point and of each predicted event.
   int cyc = 0;
   int next_idle, req_cyc, val_cyc, ov_start, to_cyc, g, last;
   bit ov_pend;
   int exp_elem, exp_end;

   task automatic model_init();
      next_idle = cyc + 1;
      req_cyc = -1;
      val_cyc = -1;
      to_cyc = -1;
      ov_pend = 0;
      last = N - 1;
      g = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_request"}, src_data_request, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_timeout"}, timeout_error, 0);
      check({tag, "_elem"}, out_trace_element, 0);
      check({tag, "_end"}, out_dec_stage_end, 0);
      check({tag, "_id"}, out_source_id, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      cyc++;
      rst_n = 1'b0;
      enable = 1'b0;
      src_data_present = '0;
      src_data_valid = '0;
      out_ready = 1'b0;
      #1;
      check_zero("reset");
      @(negedge clk);
      cyc++;
      rst_n = 1'b1;
      model_init();
   endtask

   // One cycle: compare this cycle's outputs with the timeline, then drive this cycle's inputs.
   task automatic step();
      int d, p;
      bit ov;
      @(negedge clk);
      cyc++;
      ov = ov_pend && cyc >= ov_start;
      check("request", src_data_request, (cyc == req_cyc) ? (1 << g) : 0);
      check("timeout", timeout_error, cyc == to_cyc);
      check("out_valid", out_valid, ov);
      if (ov) begin
         check("out_elem", out_trace_element, exp_elem);
         check("out_end", out_dec_stage_end, exp_end);
         check("out_id", out_source_id, g);
      end
      enable = $urandom_range(99) < en_pct;
      src_data_present = rand_pres ? N'($urandom) : force_pres;
      out_ready = $urandom_range(99) < rdy_pct;
      for (int s = 0; s < N; s++) begin
         src_data_valid[s] = (s != g) && ($urandom_range(99) < noise_pct);
         src_trace_element[s] = $urandom;
         src_dec_stage_end[s] = $urandom;
      end
      if (cyc == val_cyc) begin
         src_data_valid[g] = 1'b1;
         src_trace_element[g] = exp_elem;
         src_dec_stage_end[g] = exp_end;
      end
      if (ov && out_ready) begin
         ov_pend = 0;
         next_idle = cyc + 1;
         last = g;
      end
      if (cyc == next_idle) begin
         p = int'(src_data_present);
         if (enable && p != 0) begin
            for (int k = 1; k <= N; k++)
               if (((p >> ((last + k) % N)) & 1) != 0) begin
                  g = (last + k) % N;
                  break;
               end
            req_cyc = cyc + 1;
            if ($urandom_range(99) < stale_pct) d = 0;
            else if (d_fix != 0) d = d_fix;
            else case ($urandom_range(3))
               0: d = 1;
               1: d = 2;
               2: d = 3;
               default: d = TO;
            endcase
            if (d != 0) begin
               // Valid lands d cycles after the request; output registers load on the following edge.
               val_cyc = req_cyc + d;
               ov_start = val_cyc + 1;
               ov_pend = 1;
               exp_elem = fix_data ? 'hA5 : int'($urandom);
               exp_end = fix_data ? 42 : int'($urandom);
               next_idle = -1;
            end else begin
               // Buffer never answers: pulse TIMEOUT+1 cycles after the request, back in IDLE then.
               val_cyc = -1;
               to_cyc = req_cyc + TO + 1;
               next_idle = to_cyc;
               last = g;
            end
         end else begin
            next_idle = cyc + 1;
         end
      end
   endtask

   initial begin
      int n, p0, rc, id0, e0, n0;
      int ids [6];
      model_init();
      do_reset();
      // Nothing present: never a request.
      force_pres = '0;
      repeat (20) step();
      // Single source with fixed payload and nominal 2-cycle buffer.
      fix_data = 1;
      force_pres = 2'b01;
      p0 = cyc + 1;
      n = 0;
      do begin step(); n++; end while (!out_valid && n < 20);
      check("single_present_to_valid", cyc - p0 + 1, 5);
      check("single_elem", out_trace_element, 'hA5);
      check("single_end", out_dec_stage_end, 42);
      check("single_id", out_source_id, 0);
      fix_data = 0;
      // Fairness with both present and an always-ready consumer.
      do_reset();
      force_pres = 2'b11;
      n = 0;
      for (int i = 0; i < 6 && n < 100; ) begin
         step();
         n++;
         if (out_valid && out_ready) ids[i++] = int'(out_source_id);
      end
      for (int i = 0; i < 6; i++) check("fair_seq", ids[i], i % 2);
      // Backpressure holds the output and blocks new requests.
      rdy_pct = 0;
      n = 0;
      do begin step(); n++; end while (!out_valid && n < 40);
      check("bp_reach_valid", out_valid, 1);
      id0 = int'(out_source_id);
      e0 = out_trace_element;
      n0 = out_dec_stage_end;
      repeat (10) begin
         step();
         check("bp_valid", out_valid, 1);
         check("bp_elem", out_trace_element, e0);
         check("bp_end", out_dec_stage_end, n0);
         check("bp_no_req", src_data_request, 0);
      end
      rdy_pct = 100;
      step();
      n = 0;
      do begin step(); n++; end while (src_data_request == 0 && n < 10);
      check("bp_next_other", src_data_request, 2'b01 << (1 - id0));
      // Stale present on source 1 times out, then source 0 gets the next grant.
      force_pres = 2'b10;
      stale_pct = 100;
      n = 0;
      do begin step(); n++; end while (src_data_request != 2'b10 && n < 60);
      check("tmo_req1", src_data_request, 2'b10);
      rc = cyc;
      while (cyc < rc + TO) step();
      force_pres = 2'b11;
      stale_pct = 0;
      step();
      check("tmo_pulse", timeout_error, 1);
      step();
      check("tmo_next_src0", src_data_request, 2'b01);
      // Asynchronous reset while waiting for valid; the late valid must be ignored.
      force_pres = 2'b01;
      d_fix = 3;
      n = 0;
      do begin step(); n++; end while (src_data_request != 2'b01 && n < 40);
      check("areset_req0", src_data_request, 2'b01);
      step();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_zero("areset");
      @(negedge clk);
      cyc++;
      rst_n = 1'b1;
      src_data_present = '0;
      src_data_valid = 2'b01;
      src_trace_element[0] = 'h5A;
      src_dec_stage_end[0] = 7;
      model_init();
      force_pres = '0;
      repeat (10) step();
      check("areset_no_valid", out_valid, 0);
      // Fully random traffic.
      do_reset();
      rand_pres = 1;
      en_pct = 80;
      rdy_pct = 60;
      stale_pct = 15;
      noise_pct = 20;
      d_fix = 0;
      repeat (3000) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
